// File: rtl/mmss_counter_pkg.sv
// Shared types, digit limits and load sanitisation for the MM:SS counter.
package mmss_pkg;

    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } bcd_time_t;

    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    // Each nibble is limited to its own digit range independently.
    function automatic bcd_time_t clamp_bcd(input logic [15:0] raw);
        bcd_time_t v;
        v = raw;
        if (v.s1  > SEC_ONES_MAX) v.s1  = SEC_ONES_MAX;
        if (v.s10 > SEC_TENS_MAX) v.s10 = SEC_TENS_MAX;
        if (v.m1  > MIN_ONES_MAX) v.m1  = MIN_ONES_MAX;
        if (v.m10 > MIN_TENS_MAX) v.m10 = MIN_TENS_MAX;
        return v;
    endfunction

endpackage

// File: rtl/mmss_counter_if.sv
// Control and display bus between the MM:SS counter and its user.
interface mmss_counter_if;
    logic        run;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic        down;
    logic        tick;
    logic [15:0] digits;
    logic        rollover;
    logic        expired;

    modport master (
        output run, clear, load, load_value, down,
        input  tick, digits, rollover, expired
    );

    modport slave (
        input  run, clear, load, load_value, down,
        output tick, digits, rollover, expired
    );
endinterface

// File: rtl/mmss_counter_tick_gen.sv
// Prescaler producing a terminal-count strobe once every TICK_CYCLES run cycles.
module tick_gen #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run,
    input  logic zero,
    output logic tick
);
    localparam int unsigned W = $clog2(TICK_CYCLES);
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] count;

    // Prescaler: zeroed by reset/clear/load, advances only while running.
    always_ff @(posedge CLOCK_50) begin
        if (reset || zero) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Strobe is combinational so the owner can register tick and digits on the same edge.
    always_comb begin
        tick = run && (count == LAST) && !zero && !reset;
    end
endmodule

// File: rtl/mmss_counter.sv
// Cascaded BCD MM:SS counter with load/clear, up/down mode, rollover and expiry.
module mmss_counter
    import mmss_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    mmss_counter_if.slave  bus
);
    bcd_time_t cur;
    bcd_time_t up_val;
    bcd_time_t dn_val;
    logic      up_wrap;
    logic      strobe;
    logic      tick_q;
    logic      roll_q;
    logic      exp_q;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .run      (bus.run),
        .zero     (bus.clear || bus.load),
        .tick     (strobe)
    );

    // Next value for an up count, carrying digit by digit; wrap flags 59:59 -> 00:00.
    always_comb begin
        up_val  = cur;
        up_wrap = 1'b0;
        if (cur.s1 != SEC_ONES_MAX) begin
            up_val.s1 = cur.s1 + 4'd1;
        end else begin
            up_val.s1 = 4'd0;
            if (cur.s10 != SEC_TENS_MAX) begin
                up_val.s10 = cur.s10 + 4'd1;
            end else begin
                up_val.s10 = 4'd0;
                if (cur.m1 != MIN_ONES_MAX) begin
                    up_val.m1 = cur.m1 + 4'd1;
                end else begin
                    up_val.m1 = 4'd0;
                    if (cur.m10 != MIN_TENS_MAX) begin
                        up_val.m10 = cur.m10 + 4'd1;
                    end else begin
                        up_val.m10 = 4'd0;
                        up_wrap    = 1'b1;
                    end
                end
            end
        end
    end

    // Next value for a down count, borrowing digit by digit; only used when cur != 00:00.
    always_comb begin
        dn_val = cur;
        if (cur.s1 != 4'd0) begin
            dn_val.s1 = cur.s1 - 4'd1;
        end else begin
            dn_val.s1 = SEC_ONES_MAX;
            if (cur.s10 != 4'd0) begin
                dn_val.s10 = cur.s10 - 4'd1;
            end else begin
                dn_val.s10 = SEC_TENS_MAX;
                if (cur.m1 != 4'd0) begin
                    dn_val.m1 = cur.m1 - 4'd1;
                end else begin
                    dn_val.m1  = MIN_ONES_MAX;
                    dn_val.m10 = cur.m10 - 4'd1;
                end
            end
        end
    end

    // Registered digits and flags; reset > clear > load > tick-driven counting.
    always_ff @(posedge CLOCK_50) begin
        if (reset || bus.clear) begin
            cur    <= '0;
            tick_q <= 1'b0;
            roll_q <= 1'b0;
            exp_q  <= 1'b0;
        end else if (bus.load) begin
            cur    <= clamp_bcd(bus.load_value);
            tick_q <= 1'b0;
            roll_q <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            tick_q <= strobe;
            roll_q <= 1'b0;
            // Digits stay frozen while expired; leaving down mode releases the flag.
            if (strobe && !exp_q) begin
                if (bus.down) begin
                    if (cur != 16'h0000) cur <= dn_val;
                    if (cur == 16'h0000 || dn_val == 16'h0000) exp_q <= 1'b1;
                end else begin
                    cur    <= up_val;
                    roll_q <= up_wrap;
                end
            end
            if (!bus.down) exp_q <= 1'b0;
        end
    end

    always_comb begin
        bus.digits   = cur;
        bus.tick     = tick_q;
        bus.rollover = roll_q;
        bus.expired  = exp_q;
    end
endmodule

// File: tb/tb_mmss_counter.sv
// Self-checking bench for mmss_counter against a seconds-based reference model.
module tb_mmss_counter;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    // Reference model: total seconds 0..3599, prescaler count, and flags.
    int   m_pres, m_total;
    logic m_tick, m_roll, m_exp;

    mmss_counter_if bus();

    mmss_counter #(.TICK_CYCLES(T)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int clamp_secs(input logic [15:0] v);
        int m10, m1, s10, s1;
        m10 = (int'(v[15:12]) > 5) ? 5 : int'(v[15:12]);
        m1  = (int'(v[11:8])  > 9) ? 9 : int'(v[11:8]);
        s10 = (int'(v[7:4])   > 5) ? 5 : int'(v[7:4]);
        s1  = (int'(v[3:0])   > 9) ? 9 : int'(v[3:0]);
        return m10 * 600 + m1 * 60 + s10 * 10 + s1;
    endfunction

    function automatic logic [18:0] model_out();
        return {m_tick, m_roll, m_exp, to_bcd(m_total)};
    endfunction

    function automatic logic [18:0] dut_out();
        return {bus.tick, bus.rollover, bus.expired, bus.digits};
    endfunction

    task automatic model_update();
        logic old_exp;
        old_exp = m_exp;
        if (reset || bus.clear) begin
            m_pres = 0; m_total = 0; m_tick = 0; m_roll = 0; m_exp = 0;
        end else if (bus.load) begin
            m_pres = 0; m_total = clamp_secs(bus.load_value);
            m_tick = 0; m_roll = 0; m_exp = 0;
        end else begin
            m_tick = 0;
            m_roll = 0;
            if (bus.run) begin
                if (m_pres == T - 1) begin
                    m_pres = 0;
                    m_tick = 1;
                    if (!old_exp) begin
                        if (bus.down) begin
                            if (m_total > 0) m_total = m_total - 1;
                            if (m_total == 0) m_exp = 1;
                        end else begin
                            m_total = (m_total + 1) % 3600;
                            m_roll = (m_total == 0);
                        end
                    end
                end else begin
                    m_pres = m_pres + 1;
                end
            end
            if (!bus.down) m_exp = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.run = 0; bus.clear = 0; bus.load = 0; bus.down = 0; bus.load_value = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; bus.load = 1; bus.clear = 1; bus.load_value = 16'h1234;
        step(); step();
        checks++;
        if (dut_out() !== 19'h0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", dut_out(), 19'h0);
        end
        reset = 0; idle_inputs();
    endtask

    task automatic test_count();
        reset = 1; step(); reset = 0;
        bus.run = 1;
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++;
            if (bus.tick !== ((i % T) == 0)) begin
                failures++;
                $display("FAIL count_tick_c%0d: got %b expected %b", i, bus.tick, (i % T) == 0);
            end
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL count_model_c%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        checks++;
        if (bus.digits !== 16'h0004) begin
            failures++;
            $display("FAIL count_final: got %h expected %h", bus.digits, 16'h0004);
        end
    endtask

    task automatic test_rollover();
        int rolls;
        rolls = 0;
        bus.load = 1; bus.load_value = 16'h5958; bus.down = 0; step(); bus.load = 0;
        for (int i = 0; i < 3 * T; i++) begin
            step();
            if (bus.rollover === 1'b1) rolls++;
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL rollover_model_%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        checks++;
        if (rolls !== 1 || bus.digits !== 16'h0001) begin
            failures++;
            $display("FAIL rollover_once: got rolls=%0d digits=%h expected rolls=1 digits=0001", rolls, bus.digits);
        end
    endtask

    task automatic test_expire();
        bus.load = 1; bus.load_value = 16'h0002; bus.down = 1; step(); bus.load = 0;
        for (int i = 0; i < 4 * T; i++) begin
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL expire_model_%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        checks++;
        if (bus.expired !== 1'b1 || bus.digits !== 16'h0000) begin
            failures++;
            $display("FAIL expire_hold: got exp=%b digits=%h expected exp=1 digits=0000", bus.expired, bus.digits);
        end
        bus.clear = 1; step(); bus.clear = 0;
        checks++;
        if (bus.expired !== 1'b0) begin
            failures++;
            $display("FAIL expire_clear: got %b expected 0", bus.expired);
        end
    endtask

    task automatic test_clamp();
        bus.run = 0;
        bus.load = 1; bus.load_value = 16'hFA7C; step(); bus.load = 0;
        checks++;
        if (bus.digits !== 16'h5959) begin
            failures++;
            $display("FAIL clamp_load: got %h expected %h", bus.digits, 16'h5959);
        end
        bus.load = 1; bus.load_value = 16'h1000; bus.down = 1; step(); bus.load = 0;
        bus.run = 1;
        for (int i = 0; i < T; i++) step();
        checks++;
        if (bus.digits !== 16'h0959 || bus.tick !== 1'b1) begin
            failures++;
            $display("FAIL borrow_1000: got %h tick=%b expected 0959 tick=1", bus.digits, bus.tick);
        end
        bus.down = 0;
    endtask

    task automatic test_pause();
        int lat;
        logic [15:0] held;
        bus.load = 1; bus.load_value = 16'h0130; step(); bus.load = 0;
        bus.run = 1; step(); step();
        held = bus.digits;
        bus.run = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.digits !== held || bus.tick !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold_%0d: got %h tick=%b expected %h tick=0", i, bus.digits, bus.tick, held);
            end
        end
        bus.run = 1;
        lat = 5;
        while (bus.tick !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat != T + 3 || bus.digits !== 16'h0131) begin
            failures++;
            $display("FAIL pause_delay: got cycle %0d digits %h expected cycle %0d digits 0131", lat, bus.digits, T + 3);
        end
    endtask

    task automatic test_reset_clear_mid();
        bus.load = 1; bus.load_value = 16'h0005; step(); bus.load = 0;
        bus.run = 1; step(); step(); step();
        bus.clear = 1; step(); bus.clear = 0;
        checks++;
        if (bus.tick !== 1'b0 || bus.digits !== 16'h0000) begin
            failures++;
            $display("FAIL clear_on_tick: got tick=%b digits=%h expected tick=0 digits=0000", bus.tick, bus.digits);
        end
        bus.load = 1; bus.load_value = 16'h4321; step(); bus.load = 0;
        step(); step(); step(); step();
        reset = 1; bus.load = 1; bus.clear = 1; step();
        checks++;
        if (dut_out() !== 19'h0) begin
            failures++;
            $display("FAIL reset_mid: got %h expected %h", dut_out(), 19'h0);
        end
        reset = 0; idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            bus.clear     = ($urandom_range(0, 79) == 0);
            bus.load      = ($urandom_range(0, 39) == 0);
            bus.load_value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bus.load_value = {4'd5, 4'd9, 4'd5, 4'($urandom_range(7, 9))};
            if ($urandom_range(0, 3) == 0) bus.load_value = {12'h000, 4'($urandom_range(0, 3))};
            bus.run       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) bus.down = ~bus.down;
            step();
            checks++;
            if (dut_out() !== model_out()) begin
                failures++;
                $display("FAIL random_%0d: got %h expected %h", i, dut_out(), model_out());
            end
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        m_pres = 0; m_total = 0; m_tick = 0; m_roll = 0; m_exp = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_count();
        test_rollover();
        test_expire();
        test_clamp();
        test_pause();
        test_reset_clear_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
